// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared timing types, helpers and arcade defaults
package video_timing_pkg;

   typedef struct packed {
      int act;
      int fp;
      int sync;
      int bp;
   } timing_t;

   function automatic int tot(input timing_t t);
      return t.act + t.fp + t.sync + t.bp;
   endfunction

   function automatic int sync_start(input timing_t t);
      return t.act + t.fp;
   endfunction

   localparam timing_t ARCADE_H = '{act: 288, fp: 24, sync: 32, bp: 40};
   localparam timing_t ARCADE_V = '{act: 224, fp: 3,  sync: 7,  bp: 29};

endpackage

// File: rtl/video_axis_counter.sv
// rtl/video_axis_counter.sv - one timing axis: counter, wrap flag, blank and sync decode
module video_axis_counter
   import video_timing_pkg::*;
#(
   parameter int   PW   = 9,
   parameter int   ACT  = 288,
   parameter int   FP   = 24,
   parameter int   SYNC = 32,
   parameter int   BP   = 40,
   parameter logic POL  = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_adv,
   input  logic          i_wrap_in,
   output logic [PW-1:0] o_count,
   output logic          o_wrap,
   output logic          o_blank,
   output logic          o_sync
);

   localparam timing_t T   = '{act: ACT, fp: FP, sync: SYNC, bp: BP};
   localparam int      TOT = tot(T);
   localparam int      SS  = sync_start(T);
   localparam int      PW1 = PW + 1;

   // One extra bit so SS+SYNC == 2^PW still compares correctly
   localparam logic [PW:0] L_LAST = PW1'(TOT - 1);
   localparam logic [PW:0] L_ACT  = PW1'(ACT);
   localparam logic [PW:0] L_SS   = PW1'(SS);
   localparam logic [PW:0] L_SE   = PW1'(SS + SYNC);

   if (TOT > (1 << PW)) begin : g_tot_check
      $error("video_axis_counter: total count exceeds 2^PW");
   end

   logic [PW-1:0] r_count;
   logic [PW:0]   w_cnt_x;

   assign w_cnt_x = {1'b0, r_count};
   assign o_count = r_count;
   assign o_wrap  = (w_cnt_x == L_LAST);
   assign o_blank = (w_cnt_x >= L_ACT);
   assign o_sync  = (w_cnt_x >= L_SS && w_cnt_x < L_SE) ? POL : ~POL;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (i_adv && i_wrap_in)
         r_count <= o_wrap ? '0 : r_count + 1'b1;
   end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - CE-gated HV timing generator with flip and blanked RGB
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int   PW     = 9,
   parameter int   CW     = 12,
   parameter int   H_ACT  = ARCADE_H.act,
   parameter int   H_FP   = ARCADE_H.fp,
   parameter int   H_SYNC = ARCADE_H.sync,
   parameter int   H_BP   = ARCADE_H.bp,
   parameter int   V_ACT  = ARCADE_V.act,
   parameter int   V_FP   = ARCADE_V.fp,
   parameter int   V_SYNC = ARCADE_V.sync,
   parameter int   V_BP   = ARCADE_V.bp,
   parameter logic HS_POL = 1'b0,
   parameter logic VS_POL = 1'b0
) (
   input  logic          MCLK,
   input  logic          RESET_N,
   input  logic          CE,
   input  logic          FLIP,
   input  logic [CW-1:0] iRGB,
   output logic [PW-1:0] HPOS,
   output logic [PW-1:0] VPOS,
   output logic [CW-1:0] oRGB,
   output logic          HBLK,
   output logic          VBLK,
   output logic          HSYN,
   output logic          VSYN,
   output logic          DE,
   output logic          LSTRT,
   output logic          FSTRT,
   output logic [7:0]    FCNT
);

   localparam logic [PW-1:0] L_HMIR = PW'(H_ACT - 1);
   localparam logic [PW-1:0] L_VMIR = PW'(V_ACT - 1);

   logic [PW-1:0] w_hc, w_vc;
   logic          w_hwrap, w_vwrap, w_hblank, w_vblank, w_hsync, w_vsync;

   video_axis_counter #(
      .PW(PW), .ACT(H_ACT), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
   ) u_h (
      .clk(MCLK), .rst_n(RESET_N), .i_adv(CE), .i_wrap_in(1'b1),
      .o_count(w_hc), .o_wrap(w_hwrap), .o_blank(w_hblank), .o_sync(w_hsync)
   );

   video_axis_counter #(
      .PW(PW), .ACT(V_ACT), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
   ) u_v (
      .clk(MCLK), .rst_n(RESET_N), .i_adv(CE), .i_wrap_in(w_hwrap),
      .o_count(w_vc), .o_wrap(w_vwrap), .o_blank(w_vblank), .o_sync(w_vsync)
   );

   // Mirroring applies to the active area only; blanking positions pass through
   assign HPOS = (FLIP && !w_hblank) ? (L_HMIR - w_hc) : w_hc;
   assign VPOS = (FLIP && !w_vblank) ? (L_VMIR - w_vc) : w_vc;

   logic          r_hblk, r_vblk, r_hsyn, r_vsyn, r_lstrt, r_fstrt;
   logic [CW-1:0] r_rgb;
   logic [7:0]    r_fcnt;

   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_hblk  <= 1'b1;
         r_vblk  <= 1'b1;
         r_hsyn  <= ~HS_POL;
         r_vsyn  <= ~VS_POL;
         r_rgb   <= '0;
         r_lstrt <= 1'b0;
         r_fstrt <= 1'b0;
         r_fcnt  <= 8'd0;
      end else if (CE) begin
         r_hblk  <= w_hblank;
         r_vblk  <= w_vblank;
         r_hsyn  <= w_hsync;
         r_vsyn  <= w_vsync;
         r_rgb   <= (w_hblank | w_vblank) ? '0 : iRGB;
         r_lstrt <= w_hwrap;
         r_fstrt <= w_hwrap & w_vwrap;
         if (w_hwrap & w_vwrap)
            r_fcnt <= r_fcnt + 8'd1;
      end else begin
         r_lstrt <= 1'b0;
         r_fstrt <= 1'b0;
      end
   end

   assign HBLK  = r_hblk;
   assign VBLK  = r_vblk;
   assign HSYN  = r_hsyn;
   assign VSYN  = r_vsyn;
   assign DE    = ~(r_hblk | r_vblk);
   assign oRGB  = r_rgb;
   assign LSTRT = r_lstrt;
   assign FSTRT = r_fstrt;
   assign FCNT  = r_fcnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen
module tb_video_timing_gen;

   localparam int   HA = 20, HF = 3, HS = 4, HB = 5;
   localparam int   VA = 10, VF = 2, VS = 3, VB = 4;
   localparam int   HT = HA + HF + HS + HB;
   localparam int   VT = VA + VF + VS + VB;
   localparam int   FT = HT * VT;
   localparam logic HS_POL = 1'b0;
   localparam logic VS_POL = 1'b1;

   logic        MCLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        CE = 1'b0;
   logic        FLIP = 1'b0;
   logic [11:0] iRGB = '0;
   logic [8:0]  HPOS, VPOS;
   logic [11:0] oRGB;
   logic        HBLK, VBLK, HSYN, VSYN, DE, LSTRT, FSTRT;
   logic [7:0]  FCNT;

   video_timing_gen #(
      .PW(9), .CW(12),
      .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) dut (
      .MCLK(MCLK), .RESET_N(RESET_N), .CE(CE), .FLIP(FLIP), .iRGB(iRGB),
      .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB), .HBLK(HBLK), .VBLK(VBLK),
      .HSYN(HSYN), .VSYN(VSYN), .DE(DE), .LSTRT(LSTRT), .FSTRT(FSTRT),
      .FCNT(FCNT)
   );

   always #5 MCLK = ~MCLK;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: k = number of CE edges since reset; position is k mod frame
   int          k;
   logic        e_hblk, e_vblk, e_hsyn, e_vsyn, e_lstrt, e_fstrt;
   logic [11:0] e_rgb;
   logic [7:0]  e_fcnt;

   task automatic model_reset();
      k = 0;
      e_hblk = 1'b1; e_vblk = 1'b1;
      e_hsyn = !HS_POL; e_vsyn = !VS_POL;
      e_rgb = '0; e_lstrt = 1'b0; e_fstrt = 1'b0; e_fcnt = 8'd0;
   endtask

   task automatic model_edge(input logic ce, input logic [11:0] rgb);
      int hc, vc;
      if (ce) begin
         hc = (k % FT) % HT;
         vc = (k % FT) / HT;
         e_hblk = (hc >= HA);
         e_vblk = (vc >= VA);
         e_hsyn = (hc >= HA + HF && hc < HA + HF + HS) ? HS_POL : !HS_POL;
         e_vsyn = (vc >= VA + VF && vc < VA + VF + VS) ? VS_POL : !VS_POL;
         e_rgb  = (e_hblk || e_vblk) ? 12'h000 : rgb;
         k++;
         e_lstrt = ((k % HT) == 0);
         e_fstrt = ((k % FT) == 0);
         e_fcnt  = 8'((k / FT) % 256);
      end else begin
         e_lstrt = 1'b0;
         e_fstrt = 1'b0;
      end
   endtask

   function automatic logic [44:0] exp_vec();
      int hc, vc, hp, vp;
      hc = (k % FT) % HT;
      vc = (k % FT) / HT;
      hp = (FLIP && hc < HA) ? HA - 1 - hc : hc;
      vp = (FLIP && vc < VA) ? VA - 1 - vc : vc;
      return {e_hblk, e_vblk, e_hsyn, e_vsyn, !(e_hblk | e_vblk), e_lstrt, e_fstrt,
              e_fcnt, e_rgb, 9'(hp), 9'(vp)};
   endfunction

   function automatic logic [44:0] got_vec();
      return {HBLK, VBLK, HSYN, VSYN, DE, LSTRT, FSTRT, FCNT, oRGB, HPOS, VPOS};
   endfunction

   // Inputs change 1 time unit after the edge; outputs are sampled there too
   task automatic cycle(input logic ce, input logic [11:0] rgb);
      CE = ce;
      iRGB = rgb;
      @(posedge MCLK);
      model_edge(ce, rgb);
      #1;
   endtask

   task automatic test_reset();
      logic [44:0] g, e;
      FLIP = 1'b0;
      RESET_N = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         CE = 1'b1; iRGB = 12'(($urandom));
         @(posedge MCLK); #1;
         g = got_vec(); e = exp_vec();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL reset_hold cycle %0d got %h exp %h", i, g, e);
         end
      end
      RESET_N = 1'b1;
      #1;
      g = got_vec(); e = exp_vec();
      n_checks++;
      if (g !== e) begin
         n_fails++;
         $display("FAIL reset_release got %h exp %h", g, e);
      end
   endtask

   task automatic test_continuous();
      logic [44:0] g, e;
      int last_l = -1;
      for (int i = 1; i <= 2 * FT + 5; i++) begin
         cycle(1'b1, 12'hABC);
         g = got_vec(); e = exp_vec();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL continuous cycle %0d got %h exp %h", i, g, e);
         end
         n_checks++;
         if (oRGB !== (DE ? 12'hABC : 12'h000)) begin
            n_fails++;
            $display("FAIL rgb_blank cycle %0d got %h de %b", i, oRGB, DE);
         end
         if (i == 1) begin
            n_checks++;
            if (HBLK !== 1'b0) begin
               n_fails++;
               $display("FAIL hblk_first_edge got %b exp 0", HBLK);
            end
         end
         if (LSTRT === 1'b1) begin
            if (last_l >= 0) begin
               n_checks++;
               if (i - last_l != HT) begin
                  n_fails++;
                  $display("FAIL lstrt_period got %0d exp %0d", i - last_l, HT);
               end
            end
            last_l = i;
         end
         if (i == 2 * FT) begin
            n_checks++;
            if (FCNT !== 8'd2 || FSTRT !== 1'b1) begin
               n_fails++;
               $display("FAIL two_frames fcnt %0d fstrt %b exp 2 1", FCNT, FSTRT);
            end
         end
      end
   endtask

   task automatic test_sparse_ce();
      logic [44:0] g, e, prev;
      logic ce;
      prev = got_vec();
      for (int i = 0; i < 4 * FT + 8; i++) begin
         ce = (i % 4 == 0);
         cycle(ce, 12'($urandom));
         g = got_vec(); e = exp_vec();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL sparse_ce cycle %0d got %h exp %h", i, g, e);
         end
         if (!ce) begin
            n_checks++;
            if ({g[44:40], g[37:0]} !== {prev[44:40], prev[37:0]} || g[39:38] !== 2'b00) begin
               n_fails++;
               $display("FAIL ce_low_hold cycle %0d got %h prev %h", i, g, prev);
            end
         end
         prev = g;
      end
   endtask

   task automatic test_flip();
      logic [44:0] g, e;
      for (int i = 0; i < 2 * FT; i++) begin
         FLIP = ($urandom % 4) != 0;
         cycle(($urandom % 3) != 0, 12'($urandom));
         g = got_vec(); e = exp_vec();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL flip cycle %0d got %h exp %h", i, g, e);
         end
         FLIP = !FLIP;
         #1;
         g = got_vec(); e = exp_vec();
         n_checks++;
         if (g[17:0] !== e[17:0]) begin
            n_fails++;
            $display("FAIL flip_immediate cycle %0d got %h exp %h", i, g[17:0], e[17:0]);
         end
      end
      FLIP = 1'b0;
   endtask

   task automatic test_mid_reset();
      logic [44:0] g, e;
      int guard = 0;
      while ((k % FT) != 5 * HT + 15 && guard < 2 * FT) begin
         cycle(1'b1, 12'($urandom));
         guard++;
      end
      RESET_N = 1'b0;
      model_reset();
      #1;
      g = got_vec(); e = exp_vec();
      n_checks++;
      if (g !== e) begin
         n_fails++;
         $display("FAIL mid_reset_async got %h exp %h", g, e);
      end
      for (int i = 0; i < 3; i++) begin
         CE = 1'b1;
         @(posedge MCLK); #1;
         g = got_vec();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL mid_reset_hold cycle %0d got %h exp %h", i, g, e);
         end
      end
      RESET_N = 1'b1;
      for (int i = 0; i < 3 * HT; i++) begin
         cycle(1'b1, 12'($urandom));
         g = got_vec(); e = exp_vec();
         n_checks++;
         if (g !== e) begin
            n_fails++;
            $display("FAIL mid_reset_restart cycle %0d got %h exp %h", i, g, e);
         end
         if (i == 0) begin
            n_checks++;
            if (HPOS !== 9'd1 || VPOS !== 9'd0 || FCNT !== 8'd0) begin
               n_fails++;
               $display("FAIL restart_pos got %0d,%0d fcnt %0d exp 1,0 fcnt 0", HPOS, VPOS, FCNT);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_sparse_ce();
      test_flip();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
